airi5c_pcpi_master: RTL and testbench



---
 rtl/airi5c_pcpi_pkg.sv | 22 ++
 rtl/airi5c_pcpi_master_if.sv | 28 ++
 rtl/airi5c_pcpi_timeout.sv | 33 +++
 rtl/airi5c_pcpi_master.sv | 176 +++++++++++++++++
 tb/tb_airi5c_pcpi_master.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/airi5c_pcpi_pkg.sv
// rtl/airi5c_pcpi_pkg.sv - shared constants and FSM encoding for the PCPI master
package airi5c_pcpi_pkg;

    localparam int XPR_LEN_DEF        = 32;
    localparam int REG_ADDR_WIDTH_DEF = 5;

    localparam logic [6:0] OPC_CUSTOM = 7'h77;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t REQ   = 3'd1;
    localparam state_t WAIT  = 3'd2;
    localparam state_t RESP  = 3'd3;
    localparam state_t TRAP  = 3'd4;
    localparam state_t DRAIN = 3'd5;

    function automatic logic is_custom(input logic [31:0] insn);
        return insn[6:0] == OPC_CUSTOM;
    endfunction

endpackage

// File: rtl/airi5c_pcpi_master_if.sv
// rtl/airi5c_pcpi_master_if.sv - PCPI request/response bus between core and coprocessors
interface airi5c_pcpi_master_if
    import airi5c_pcpi_pkg::*;
#(
    parameter int XPR_LEN = XPR_LEN_DEF
);
    logic               pcpi_valid;
    logic [XPR_LEN-1:0] pcpi_insn;
    logic [XPR_LEN-1:0] pcpi_rs1;
    logic [XPR_LEN-1:0] pcpi_rs2;
    logic [XPR_LEN-1:0] pcpi_rs3;
    logic               pcpi_wr;
    logic [XPR_LEN-1:0] pcpi_rd;
    logic [XPR_LEN-1:0] pcpi_rd2;
    logic               pcpi_use_rd64;
    logic               pcpi_wait;
    logic               pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3,
        input  pcpi_wr, pcpi_rd, pcpi_rd2, pcpi_use_rd64, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3,
        output pcpi_wr, pcpi_rd, pcpi_rd2, pcpi_use_rd64, pcpi_wait, pcpi_ready
    );
endinterface

// File: rtl/airi5c_pcpi_timeout.sv
// rtl/airi5c_pcpi_timeout.sv - loadable down-counter with terminal-count flag
module airi5c_pcpi_timeout #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             tc
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/airi5c_pcpi_master.sv
// rtl/airi5c_pcpi_master.sv - core-side PCPI initiator: offload, stall, write-back or trap
module airi5c_pcpi_master
    import airi5c_pcpi_pkg::*;
#(
    parameter int XPR_LEN        = XPR_LEN_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int TIMEOUT        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic [XPR_LEN-1:0]        req_insn,
    input  logic [XPR_LEN-1:0]        req_rs1,
    input  logic [XPR_LEN-1:0]        req_rs2,
    input  logic [XPR_LEN-1:0]        req_rs3,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd_addr,
    input  logic                      kill,
    output logic                      stall,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr,
    output logic [XPR_LEN-1:0]        wb_data,
    output logic [XPR_LEN-1:0]        wb_data2,
    output logic                      wb_use_rd64,
    output logic                      illegal_insn,
    airi5c_pcpi_master_if.master      pcpi
);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t state_q, state_d;

    logic [XPR_LEN-1:0]        insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [XPR_LEN-1:0]        rd_q, rd_d, rd2_q, rd2_d;
    logic                      wr_q, wr_d, use_rd64_q, use_rd64_d;

    logic accept, capture, tmr_dec, tmr_tc;
    logic pcpi_valid_o;

    airi5c_pcpi_timeout #(.WIDTH(CNT_W)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (CNT_W'(TIMEOUT - 1)),
        .dec      (tmr_dec),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            insn_q     <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs3_q      <= '0;
            rd_addr_q  <= '0;
            rd_q       <= '0;
            rd2_q      <= '0;
            wr_q       <= 1'b0;
            use_rd64_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            insn_q     <= insn_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs3_q      <= rs3_d;
            rd_addr_q  <= rd_addr_d;
            rd_q       <= rd_d;
            rd2_q      <= rd2_d;
            wr_q       <= wr_d;
            use_rd64_q <= use_rd64_d;
        end
    end

    // Kill outranks a coincident ready; DRAIN swallows a ready that may still be in flight.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        tmr_dec = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !kill) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (pcpi.pcpi_ready) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (pcpi.pcpi_wait) begin
                    state_d = WAIT;
                end else if (tmr_tc) begin
                    state_d = TRAP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            WAIT: begin
                if (kill && pcpi.pcpi_ready) begin
                    state_d = IDLE;
                end else if (kill) begin
                    state_d = DRAIN;
                end else if (pcpi.pcpi_ready) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            TRAP:    state_d = IDLE;
            DRAIN: begin
                if (pcpi.pcpi_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        insn_d     = insn_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs3_d      = rs3_q;
        rd_addr_d  = rd_addr_q;
        rd_d       = rd_q;
        rd2_d      = rd2_q;
        wr_d       = wr_q;
        use_rd64_d = use_rd64_q;
        if (accept) begin
            insn_d    = req_insn;
            rs1_d     = req_rs1;
            rs2_d     = req_rs2;
            rs3_d     = req_rs3;
            rd_addr_d = req_rd_addr;
        end
        if (capture) begin
            wr_d       = pcpi.pcpi_wr;
            rd_d       = pcpi.pcpi_rd;
            rd2_d      = pcpi.pcpi_rd2;
            use_rd64_d = pcpi.pcpi_use_rd64;
        end
    end

    always_comb begin
        pcpi_valid_o = 1'b0;
        stall        = 1'b0;
        wb_valid     = 1'b0;
        illegal_insn = 1'b0;
        case (state_q)
            IDLE:  stall = req_valid;
            REQ, WAIT: begin
                pcpi_valid_o = 1'b1;
                stall        = 1'b1;
            end
            RESP:  wb_valid     = wr_q & ~kill;
            TRAP:  illegal_insn = ~kill;
            DRAIN: stall        = 1'b1;
            default: ;
        endcase
    end

    assign pcpi.pcpi_valid = pcpi_valid_o;
    assign pcpi.pcpi_insn  = insn_q;
    assign pcpi.pcpi_rs1   = rs1_q;
    assign pcpi.pcpi_rs2   = rs2_q;
    assign pcpi.pcpi_rs3   = rs3_q;

    assign wb_addr     = rd_addr_q;
    assign wb_data     = rd_q;
    assign wb_data2    = rd2_q;
    assign wb_use_rd64 = use_rd64_q;

endmodule

// File: tb/tb_airi5c_pcpi_master.sv
// tb/tb_airi5c_pcpi_master.sv - directed self-checking bench for airi5c_pcpi_master
module tb_airi5c_pcpi_master;
    import airi5c_pcpi_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_insn, req_rs1, req_rs2, req_rs3;
    logic [4:0]  req_rd_addr;
    logic        kill;
    logic        stall, wb_valid, wb_use_rd64, illegal_insn;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, wb_data2;

    airi5c_pcpi_master_if #(.XPR_LEN(32)) pcpi_bus ();

    airi5c_pcpi_master #(.XPR_LEN(32), .REG_ADDR_WIDTH(5), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_insn     (req_insn),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_rs3      (req_rs3),
        .req_rd_addr  (req_rd_addr),
        .kill         (kill),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_data2     (wb_data2),
        .wb_use_rd64  (wb_use_rd64),
        .illegal_insn (illegal_insn),
        .pcpi         (pcpi_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bitrev(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // Responder: 0 none, 1 bit-reverse (claim, ready 2 cycles later), 2 fixed 64-bit, 3 zero-wait bit-reverse
    int resp_mode = 0;

    initial begin
        int          k;
        int          r_mode;
        logic        busy;
        logic [31:0] r_rs1;
        busy = 1'b0;
        k = 0;
        r_mode = 0;
        r_rs1 = '0;
        pcpi_bus.pcpi_wait = 1'b0;
        pcpi_bus.pcpi_ready = 1'b0;
        pcpi_bus.pcpi_wr = 1'b0;
        pcpi_bus.pcpi_rd = '0;
        pcpi_bus.pcpi_rd2 = '0;
        pcpi_bus.pcpi_use_rd64 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pcpi_bus.pcpi_ready = 1'b0;
            pcpi_bus.pcpi_wr = 1'b0;
            pcpi_bus.pcpi_rd = '0;
            pcpi_bus.pcpi_rd2 = '0;
            pcpi_bus.pcpi_use_rd64 = 1'b0;
            if (busy) begin
                k++;
                if (k == 3) begin
                    busy = 1'b0;
                    pcpi_bus.pcpi_wait = 1'b0;
                    pcpi_bus.pcpi_ready = 1'b1;
                    pcpi_bus.pcpi_wr = 1'b1;
                    if (r_mode == 2) begin
                        pcpi_bus.pcpi_rd = 32'h12345678;
                        pcpi_bus.pcpi_rd2 = 32'h9ABCDEF0;
                        pcpi_bus.pcpi_use_rd64 = 1'b1;
                    end else begin
                        pcpi_bus.pcpi_rd = bitrev(r_rs1);
                    end
                end
            end else if (pcpi_bus.pcpi_valid && resp_mode != 0 && is_custom(pcpi_bus.pcpi_insn)) begin
                r_mode = resp_mode;
                r_rs1 = pcpi_bus.pcpi_rs1;
                if (resp_mode == 3) begin
                    pcpi_bus.pcpi_ready = 1'b1;
                    pcpi_bus.pcpi_wr = 1'b1;
                    pcpi_bus.pcpi_rd = bitrev(r_rs1);
                end else begin
                    busy = 1'b1;
                    k = 1;
                    pcpi_bus.pcpi_wait = 1'b1;
                end
            end
        end
    end

    int          o_pv, o_pv_first, o_wb_cnt, o_trap_cnt, o_trap_cyc, o_pay_bad;
    int          o_wb_cyc [2];
    logic [31:0] o_wb_d [2];
    logic [4:0]  o_wb_a;
    logic [31:0] o_d2;
    logic        o_rd64, o_wb_stall, o_trap_stall, o_pv3, o_st3, o_any3, o_pv4;

    task automatic sample(input int c);
        if (pcpi_bus.pcpi_valid) begin
            o_pv++;
            if (o_pv_first < 0) o_pv_first = c;
            if ({pcpi_bus.pcpi_insn, pcpi_bus.pcpi_rs2, pcpi_bus.pcpi_rs3} !== {req_insn, req_rs2, req_rs3})
                o_pay_bad++;
        end
        if (wb_valid) begin
            if (o_wb_cnt < 2) begin
                o_wb_cyc[o_wb_cnt] = c;
                o_wb_d[o_wb_cnt] = wb_data;
            end
            if (o_wb_cnt == 0) begin
                o_wb_a = wb_addr;
                o_d2 = wb_data2;
                o_rd64 = wb_use_rd64;
                o_wb_stall = stall;
            end
            o_wb_cnt++;
        end
        if (illegal_insn) begin
            o_trap_cnt++;
            o_trap_cyc = c;
            o_trap_stall = stall;
        end
        if (c == 3) begin
            o_pv3 = pcpi_bus.pcpi_valid;
            o_st3 = stall;
            o_any3 = |{pcpi_bus.pcpi_valid, stall, wb_valid, illegal_insn, wb_use_rd64, wb_addr,
                       wb_data, wb_data2, pcpi_bus.pcpi_insn, pcpi_bus.pcpi_rs1};
        end
        if (c == 4) o_pv4 = pcpi_bus.pcpi_valid;
    endtask

    // Cycle 0 is the first cycle req_valid is high; req_valid stays up through cycle hold_c.
    task automatic run(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs1b,
                       input logic [4:0] rd, input int mode, input int hold_c,
                       input int kill_c, input int rst_c);
        o_pv = 0; o_pv_first = -1; o_wb_cnt = 0; o_trap_cnt = 0; o_trap_cyc = -1; o_pay_bad = 0;
        o_wb_cyc[0] = -1; o_wb_cyc[1] = -1; o_wb_d[0] = '0; o_wb_d[1] = '0;
        o_wb_a = '0; o_d2 = '0; o_rd64 = 1'b0; o_wb_stall = 1'b1; o_trap_stall = 1'b1;
        o_pv3 = 1'bx; o_st3 = 1'bx; o_any3 = 1'bx; o_pv4 = 1'bx;
        resp_mode = mode;
        @(posedge clk);
        #1;
        req_insn = insn;
        req_rs1 = rs1;
        req_rs2 = ~rs1;
        req_rs3 = rs1 ^ 32'h5A5A5A5A;
        req_rd_addr = rd;
        req_valid = 1'b1;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            sample(c);
            @(posedge clk);
            #1;
            if (c == 0) req_rs1 = rs1b;
            if (c + 1 > hold_c) req_valid = 1'b0;
            kill = (c + 1 == kill_c);
            reset = (c + 1 == rst_c);
        end
    endtask

    typedef struct {
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [4:0]  rd;
        int          mode;
        int          e_pv;
        int          e_wb_cyc;
        logic [31:0] e_d;
        logic [31:0] e_d2;
        logic        e_rd64;
        int          e_trap_cyc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{32'h00208077, 32'h00000001, 5'd5,  1, 3,  4, 32'h80000000, 32'h0, 1'b0, -1};
        vecs[1] = '{32'h002080B3, 32'h00000001, 5'd7,  1, 16, -1, 32'h0, 32'h0, 1'b0, 17};
        vecs[2] = '{32'h00000077, 32'hDEADBEEF, 5'd9,  2, 3,  4, 32'h12345678, 32'h9ABCDEF0, 1'b1, -1};
        vecs[3] = '{32'h12345077, 32'h000000F0, 5'd31, 3, 1,  2, 32'h0F000000, 32'h0, 1'b0, -1};
        vecs[4] = '{32'h00000077, 32'hA5A50000, 5'd1,  1, 3,  4, 32'h0000A5A5, 32'h0, 1'b0, -1};
        vecs[5] = '{32'h00000077, 32'h00000003, 5'd2,  0, 16, -1, 32'h0, 32'h0, 1'b0, 17};

        reset = 1'b1; kill = 1'b0; req_valid = 1'b0;
        req_insn = '0; req_rs1 = '0; req_rs2 = '0; req_rs3 = '0; req_rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(|{pcpi_bus.pcpi_valid, stall, wb_valid, illegal_insn, wb_use_rd64, wb_addr,
                                   wb_data, wb_data2, pcpi_bus.pcpi_insn, pcpi_bus.pcpi_rs1}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].insn, vecs[i].rs1, vecs[i].rs1, vecs[i].rd, vecs[i].mode, 0, -1, -1);
            chk($sformatf("v%0d_pv_cycles", i), o_pv, vecs[i].e_pv);
            chk($sformatf("v%0d_pv_first", i), o_pv_first, 1);
            chk($sformatf("v%0d_payload", i), o_pay_bad, 0);
            chk($sformatf("v%0d_wb_count", i), o_wb_cnt, (vecs[i].e_wb_cyc >= 0) ? 1 : 0);
            chk($sformatf("v%0d_trap_count", i), o_trap_cnt, (vecs[i].e_trap_cyc >= 0) ? 1 : 0);
            if (vecs[i].e_wb_cyc >= 0) begin
                chk($sformatf("v%0d_wb_cycle", i), o_wb_cyc[0], vecs[i].e_wb_cyc);
                chk($sformatf("v%0d_wb_addr", i), 32'(o_wb_a), 32'(vecs[i].rd));
                chk($sformatf("v%0d_wb_data", i), o_wb_d[0], vecs[i].e_d);
                chk($sformatf("v%0d_wb_data2", i), o_d2, vecs[i].e_d2);
                chk($sformatf("v%0d_wb_rd64", i), 32'(o_rd64), 32'(vecs[i].e_rd64));
                chk($sformatf("v%0d_wb_stall", i), 32'(o_wb_stall), 32'd0);
            end
            if (vecs[i].e_trap_cyc >= 0) begin
                chk($sformatf("v%0d_trap_cycle", i), o_trap_cyc, vecs[i].e_trap_cyc);
                chk($sformatf("v%0d_trap_stall", i), 32'(o_trap_stall), 32'd0);
            end
        end

        // kill while the coprocessor is working: DRAIN must eat the late ready
        run(32'h00000077, 32'h00000001, 32'h00000001, 5'd4, 1, 0, 2, -1);
        chk("kill_pv_c3", 32'(o_pv3), 32'd0);
        chk("kill_stall_c3", 32'(o_st3), 32'd1);
        chk("kill_pv_cycles", o_pv, 2);
        chk("kill_wb_count", o_wb_cnt, 0);
        chk("kill_trap_count", o_trap_cnt, 0);
        run(32'h00000077, 32'hF0000000, 32'hF0000000, 5'd3, 1, 0, -1, -1);
        chk("after_kill_wb_count", o_wb_cnt, 1);
        chk("after_kill_wb_cycle", o_wb_cyc[0], 4);
        chk("after_kill_wb_data", o_wb_d[0], 32'h0000000F);

        // back-to-back with req_valid held
        run(32'h00000077, 32'h00000001, 32'h00000002, 5'd5, 1, 5, -1, -1);
        chk("b2b_wb_count", o_wb_cnt, 2);
        chk("b2b_wb0_data", o_wb_d[0], 32'h80000000);
        chk("b2b_wb1_data", o_wb_d[1], 32'h40000000);
        chk("b2b_wb0_cycle", o_wb_cyc[0], 4);
        chk("b2b_wb1_cycle", o_wb_cyc[1], 9);
        chk("b2b_pv_gap_c4", 32'(o_pv4), 32'd0);
        chk("b2b_pv_cycles", o_pv, 6);

        // reset while in WAIT
        run(32'h00000077, 32'h00000001, 32'h00000001, 5'd6, 1, 0, -1, 2);
        chk("rst_wait_outputs_c3", 32'(o_any3), 32'd0);
        chk("rst_wait_wb_count", o_wb_cnt, 0);
        chk("rst_wait_trap_count", o_trap_cnt, 0);
        chk("rst_wait_pv_cycles", o_pv, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
